// File: rtl/alu_accumulator.sv
// Purpose: sequential front-end and 64-bit result register for the combinational opcode ALU.
// Latency: ALU op response SETTLE_CYCLES+1 cycles after the command handshake; local/illegal op 1 cycle.
// Backpressure: one command in flight; cmd_ready low in WAIT/DONE, response held until rsp_ready.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_opcode (4b), cmd_operand (32b)
//   rsp_valid/rsp_ready         response handshake; rsp_data (64b accumulator), rsp_err (2b)
//   err_sticky                  OR of ALU errors since the last rst/CLEAR
//   busy                        high whenever the FSM is not IDLE
//   alu_a/alu_b/alu_opcode      drive the external ALU
//   alu_c/alu_err               result and error returned by the ALU
//
// Build option: define ACC_ERR_LOCK_EN to suppress ALU issue while err_sticky is non-zero.

module alu_accumulator #(
    parameter int unsigned SETTLE_CYCLES = 2,       // legal range 1..15
    parameter logic [63:0] ACC_RESET     = 64'h0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [31:0] cmd_operand,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_err,

    output logic [1:0]  err_sticky,
    output logic        busy,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [63:0] alu_c,
    input  logic [1:0]  alu_err
);

    // ------------------------------------------------------------------
    // Opcodes and types
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_CLEAR = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_MOD   = 4'b1000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    // The settle counter counts down to zero; the zero cycle is the capture cycle.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_NOP     = 3'd1,
        CLS_CLEAR   = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] operand;
    } cmd_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  err;
    } rsp_t;

    function automatic op_class_t decode_op(input logic [3:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_DIV, OP_MOD: cls = CLS_ALU;
            OP_NOP:                         cls = CLS_NOP;
            OP_CLEAR:                       cls = CLS_CLEAR;
            OP_LOAD:                        cls = CLS_LOAD;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [63:0] acc;
    logic [3:0]  cnt;
    rsp_t        rsp_q;

    cmd_t        cmd_in;
    op_class_t   cmd_cls;
    logic        cmd_fire;
    logic        alu_lock;
    logic        alu_issue;
    logic        capture;
    logic [63:0] acc_after_alu;

    assign cmd_in    = '{opcode: cmd_opcode, operand: cmd_operand};
    assign cmd_cls   = decode_op(cmd_in.opcode);
    assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef ACC_ERR_LOCK_EN
    // Any recorded error freezes ALU issue until CLEAR or rst.
    assign alu_lock  = (err_sticky != ERR_NONE);
`else
    assign alu_lock  = 1'b0;
`endif

    // A locked ALU op is answered like a local op: straight to DONE.
    assign alu_issue = (cmd_cls == CLS_ALU) && !alu_lock;

    // Capture in the last WAIT cycle; an erroring result leaves acc untouched.
    assign capture       = (state == WAIT) && (cnt == 4'd0);
    assign acc_after_alu = (alu_err == ERR_NONE) ? alu_c : acc;

    assign rsp_data = rsp_q.data;
    assign rsp_err  = rsp_q.err;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = alu_issue ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, error flags, ALU drive, response register.
    // The response register is only written on the way into DONE, so it
    // stays stable for as long as the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= ACC_RESET;
            err_sticky <= ERR_NONE;
            cnt        <= 4'd0;
            rsp_q      <= '0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_opcode <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        case (cmd_cls)
                            CLS_ALU: begin
                                if (alu_issue) begin
                                    // Only the low word of acc feeds back to the ALU.
                                    alu_a      <= acc[31:0];
                                    alu_b      <= cmd_in.operand;
                                    alu_opcode <= cmd_in.opcode;
                                    cnt        <= CNT_INIT;
                                end else begin
                                    rsp_q <= '{data: acc, err: err_sticky};
                                end
                            end
                            CLS_NOP: begin
                                rsp_q <= '{data: acc, err: ERR_NONE};
                            end
                            CLS_CLEAR: begin
                                acc        <= ACC_RESET;
                                err_sticky <= ERR_NONE;
                                rsp_q      <= '{data: ACC_RESET, err: ERR_NONE};
                            end
                            CLS_LOAD: begin
                                acc   <= {32'd0, cmd_in.operand};
                                rsp_q <= '{data: {32'd0, cmd_in.operand}, err: ERR_NONE};
                            end
                            default: begin
                                rsp_q <= '{data: acc, err: ERR_ILLEGAL};
                            end
                        endcase
                    end
                end
                WAIT: begin
                    if (capture) begin
                        acc        <= acc_after_alu;
                        err_sticky <= err_sticky | alu_err;
                        rsp_q      <= '{data: acc_after_alu, err: alu_err};
                        // alu_a/alu_b keep their values; only the opcode returns to NOP.
                        alu_opcode <= OP_NOP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    // DONE: hold everything until the response is taken.
                end
            endcase
        end
    end

endmodule
